// File: rtl/tetris_pkg.sv
// Shared command/state definitions for the tetris scheduler and core.
package tetris_pkg;

    localparam int unsigned CMD_W = 3;
    localparam int unsigned BTN_W = 6;
    localparam int unsigned LVL_W = 4;
    localparam int unsigned CNT_W = 32;

    // Button bit positions within btn_req
    localparam int unsigned BTN_LEFT   = 0;
    localparam int unsigned BTN_RIGHT  = 1;
    localparam int unsigned BTN_ROTATE = 2;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_DROP   = 4;
    localparam int unsigned BTN_HOLD   = 5;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DOWN   = 3'd4,
        CMD_DROP   = 3'd5,
        CMD_HOLD   = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } sched_state_e;

    // Fixed priority: hold > drop > rotate > left > right > down/gravity
    function automatic cmd_e pick_winner(input logic [BTN_W-1:0] pend, input logic grav);
        cmd_e win;
        win = CMD_NONE;
        if (pend[BTN_HOLD])                     win = CMD_HOLD;
        else if (pend[BTN_DROP])                win = CMD_DROP;
        else if (pend[BTN_ROTATE])              win = CMD_ROTATE;
        else if (pend[BTN_LEFT])                win = CMD_LEFT;
        else if (pend[BTN_RIGHT])               win = CMD_RIGHT;
        else if (pend[BTN_DOWN] || grav)        win = CMD_DOWN;
        return win;
    endfunction

    // Pending-bit mask served by a given command
    function automatic logic [BTN_W-1:0] cmd_to_btn(input cmd_e cmd);
        logic [BTN_W-1:0] m;
        m = '0;
        case (cmd)
            CMD_LEFT:   m[BTN_LEFT]   = 1'b1;
            CMD_RIGHT:  m[BTN_RIGHT]  = 1'b1;
            CMD_ROTATE: m[BTN_ROTATE] = 1'b1;
            CMD_DOWN:   m[BTN_DOWN]   = 1'b1;
            CMD_DROP:   m[BTN_DROP]   = 1'b1;
            CMD_HOLD:   m[BTN_HOLD]   = 1'b1;
            default:    m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tetris_gravity_timer.sv
// Level-dependent gravity counter; tick marks the cycle the count wraps.
module tetris_gravity_timer
    import tetris_pkg::*;
#(
    parameter int unsigned GRAV_BASE = 50_000_000,
    parameter int unsigned GRAV_STEP = 3_000_000,
    parameter int unsigned GRAV_MIN  = 5_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LVL_W-1:0] level,
    input  logic             freeze,
    input  logic             restart,
    output logic             tick
);

    localparam int unsigned PROD_W = CNT_W + LVL_W;

    logic [CNT_W-1:0]  r_cnt;
    logic [PROD_W-1:0] w_dec;
    logic [CNT_W-1:0]  w_sub;
    logic [CNT_W-1:0]  w_period;
    logic [CNT_W-1:0]  w_last;
    logic              w_wrap;

    // Saturating period: max(GRAV_MIN, GRAV_BASE - level*GRAV_STEP), never below 1
    always_comb begin
        w_dec    = PROD_W'(level) * PROD_W'(GRAV_STEP);
        w_sub    = (w_dec >= PROD_W'(GRAV_BASE)) ? '0 : CNT_W'(PROD_W'(GRAV_BASE) - w_dec);
        w_period = (w_sub < CNT_W'(GRAV_MIN)) ? CNT_W'(GRAV_MIN) : w_sub;
        w_last   = (w_period == '0) ? '0 : w_period - CNT_W'(1);
        // >= so a level change that shortens the period cannot strand the count
        w_wrap   = (r_cnt >= w_last);
    end

    assign tick = !freeze && !restart && w_wrap;

    // Counter: restart wins, freeze holds, otherwise count and wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (!freeze) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tetris_cmd_sched.sv
// Merges button requests and gravity into single commands for the tetris core.
module tetris_cmd_sched
    import tetris_pkg::*;
#(
    parameter int unsigned GRAV_BASE = 50_000_000,
    parameter int unsigned GRAV_STEP = 3_000_000,
    parameter int unsigned GRAV_MIN  = 5_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BTN_W-1:0] btn_req,
    input  logic [LVL_W-1:0] level,
    input  logic             pause,
    input  logic             ready,
    output logic [CMD_W-1:0] ctrl,
    output logic             busy
);

    sched_state_e     r_state;
    sched_state_e     w_next;
    cmd_e             r_win;
    cmd_e             w_win_nxt;
    cmd_e             r_ctrl;
    cmd_e             w_ctrl_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [BTN_W-1:0] r_pend;
    logic [BTN_W-1:0] w_pend_nxt;
    logic [BTN_W-1:0] w_clr;
    logic             r_grav;
    logic             w_grav_nxt;
    logic             w_tick;
    logic             w_restart;

    tetris_gravity_timer #(
        .GRAV_BASE (GRAV_BASE),
        .GRAV_STEP (GRAV_STEP),
        .GRAV_MIN  (GRAV_MIN)
    ) u_grav (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .freeze  (pause),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Any downward move resets the gravity timer
    assign w_restart = (r_state == ST_ISSUE) && ((r_win == CMD_DOWN) || (r_win == CMD_DROP));

    // Sticky requests; clearing the issued source overrides a same-cycle pulse
    always_comb begin
        w_clr = '0;
        if (r_state == ST_ISSUE) begin
            w_clr = cmd_to_btn(r_win);
        end
        w_pend_nxt = (r_pend | btn_req) & ~w_clr;
        w_grav_nxt = (r_grav | w_tick) & ~w_restart;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, winner selection and next registered output values
    always_comb begin
        w_next    = r_state;
        w_win_nxt = r_win;
        case (r_state)
            ST_IDLE: begin
                if (ready && !pause && ((|r_pend) || r_grav)) begin
                    w_next    = ST_ISSUE;
                    w_win_nxt = pick_winner(r_pend, r_grav);
                end
            end
            ST_ISSUE:  w_next = ST_SETTLE;
            ST_SETTLE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (ready) begin
                    w_next = ST_IDLE;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
        w_ctrl_nxt = (w_next == ST_ISSUE) ? w_win_nxt : CMD_NONE;
        w_busy_nxt = (w_next != ST_IDLE);
    end

    // Pending bits, latched winner and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            r_grav <= 1'b0;
            r_win  <= CMD_NONE;
            r_ctrl <= CMD_NONE;
            r_busy <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_grav <= w_grav_nxt;
            r_win  <= w_win_nxt;
            r_ctrl <= w_ctrl_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign ctrl = r_ctrl;
    assign busy = r_busy;

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// Self-checking bench for tetris_cmd_sched: directed vectors plus random traffic vs a cycle model.
module tb_tetris_cmd_sched;

    localparam int GB = 100;
    localparam int GS = 10;
    localparam int GM = 20;

    logic       clk;
    logic       reset_n;
    logic [5:0] btn_req;
    logic [3:0] level;
    logic       pause;
    logic       ready;
    logic [2:0] ctrl;
    logic       busy;

    int n_cmp;
    int n_err;

    tetris_cmd_sched #(
        .GRAV_BASE (GB),
        .GRAV_STEP (GS),
        .GRAV_MIN  (GM)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_req (btn_req),
        .level   (level),
        .pause   (pause),
        .ready   (ready),
        .ctrl    (ctrl),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pending requests indexed by command code; m_age counts cycles since issue (-1 = no command)
    bit [6:1] m_pend;
    bit       m_grav;
    int       m_cnt;
    int       m_age;
    int       m_cmd;
    int       prio [6] = '{6, 5, 3, 1, 2, 4};

    function automatic int period_of(input int lv);
        int p;
        p = GB - lv * GS;
        if (p < GM) p = GM;
        return p;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_grav = 1'b0;
        m_cnt  = 0;
        m_age  = -1;
        m_cmd  = 0;
    endtask

    task automatic model_clock();
        bit       tick;
        bit       restart;
        bit       ng;
        bit [6:1] np;
        restart = (m_age == 0) && (m_cmd == 4 || m_cmd == 5);
        tick    = 1'b0;
        if (restart) m_cnt = 0;
        else if (!pause) begin
            if (m_cnt >= period_of(int'(level)) - 1) begin
                m_cnt = 0;
                tick  = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        np = m_pend;
        for (int b = 0; b < 6; b++) if (btn_req[b]) np[b+1] = 1'b1;
        if (m_age == 0) np[m_cmd] = 1'b0;
        ng = (m_grav || tick) && !restart;
        if (m_age < 0) begin
            if (ready && !pause) begin
                for (int i = 0; i < 6; i++) begin
                    if (m_age < 0 && (m_pend[prio[i]] || (prio[i] == 4 && m_grav))) begin
                        m_cmd = prio[i];
                        m_age = 0;
                    end
                end
            end
        end else if (m_age >= 2) begin
            if (ready) m_age = -1;
        end else begin
            m_age = m_age + 1;
        end
        m_pend = np;
        m_grav = ng;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: advance model on current inputs, then compare after the edge
    task automatic step();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        check("model_ctrl", int'(ctrl), (m_age == 0) ? m_cmd : 0);
        check("model_busy", int'(busy), (m_age >= 0) ? 1 : 0);
    endtask

    task automatic wait_cmd(input int c, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (int'(ctrl) != c && n < limit);
        if (int'(ctrl) != c) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_cmd timeout: got ctrl %0d after %0d cycles, expected %0d", ctrl, n, c);
        end
    endtask

    typedef struct {
        logic [5:0] btn;
        logic       rdy;
        logic [2:0] ectrl;
        logic       ebusy;
    } vec_t;

    vec_t vt [32];
    int   lv_tab [4] = '{0, 3, 9, 15};
    int   iv_tab [4] = '{102, 72, 22, 22};

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tot;
        int seen_rot;
        int bad;

        // single LEFT, busy until ready returns
        vt[0]  = '{6'b000001, 1'b1, 3'd0, 1'b0};
        vt[1]  = '{6'b000000, 1'b1, 3'd1, 1'b1};
        vt[2]  = '{6'b000000, 1'b0, 3'd0, 1'b1};
        vt[3]  = '{6'b000000, 1'b0, 3'd0, 1'b1};
        vt[4]  = '{6'b000000, 1'b0, 3'd0, 1'b1};
        vt[5]  = '{6'b000000, 1'b1, 3'd0, 1'b0};
        // hold+drop+left together -> 6, 5, 1
        vt[6]  = '{6'b110001, 1'b1, 3'd0, 1'b0};
        vt[7]  = '{6'b000000, 1'b1, 3'd6, 1'b1};
        vt[8]  = '{6'b000000, 1'b0, 3'd0, 1'b1};
        vt[9]  = '{6'b000000, 1'b1, 3'd0, 1'b1};
        vt[10] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        vt[11] = '{6'b000000, 1'b1, 3'd5, 1'b1};
        vt[12] = '{6'b000000, 1'b1, 3'd0, 1'b1};
        vt[13] = '{6'b000000, 1'b1, 3'd0, 1'b1};
        vt[14] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        vt[15] = '{6'b000000, 1'b1, 3'd1, 1'b1};
        vt[16] = '{6'b000000, 1'b1, 3'd0, 1'b1};
        vt[17] = '{6'b000000, 1'b1, 3'd0, 1'b1};
        vt[18] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        vt[19] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        // rotate in flight, LEFT in WAIT, LEFT again in its own ISSUE cycle
        vt[20] = '{6'b000100, 1'b1, 3'd0, 1'b0};
        vt[21] = '{6'b000000, 1'b1, 3'd3, 1'b1};
        vt[22] = '{6'b000000, 1'b0, 3'd0, 1'b1};
        vt[23] = '{6'b000001, 1'b0, 3'd0, 1'b1};
        vt[24] = '{6'b000000, 1'b0, 3'd0, 1'b1};
        vt[25] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        vt[26] = '{6'b000000, 1'b1, 3'd1, 1'b1};
        vt[27] = '{6'b000001, 1'b1, 3'd0, 1'b1};
        vt[28] = '{6'b000000, 1'b1, 3'd0, 1'b1};
        vt[29] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        vt[30] = '{6'b000000, 1'b1, 3'd0, 1'b0};
        vt[31] = '{6'b000000, 1'b1, 3'd0, 1'b0};

        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        btn_req = '0;
        level   = '0;
        pause   = 1'b0;
        ready   = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_ctrl", int'(ctrl), 0);
        check("reset_busy", int'(busy), 0);
        reset_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 32; i++) begin
            btn_req = vt[i].btn;
            ready   = vt[i].rdy;
            step();
            check($sformatf("vec%0d_ctrl", i), int'(ctrl), int'(vt[i].ectrl));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].ebusy));
        end
        btn_req = '0;

        // gravity spacing per level: period + 2 cycles of issue overhead
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            level = 4'(lv_tab[k]);
            wait_cmd(4, 400, n);
            wait_cmd(4, 400, n);
            check($sformatf("grav_interval_lv%0d", lv_tab[k]), n, iv_tab[k]);
        end

        // pause: rotate recorded but held, gravity count frozen then resumed
        level = 4'd0;
        wait_cmd(4, 400, n);
        tot = 0;
        repeat (31) begin step(); tot++; end
        pause   = 1'b1;
        btn_req = 6'b000100;
        bad     = 0;
        repeat (500) begin
            step();
            tot++;
            btn_req = '0;
            if (ctrl != 3'd0) bad++;
        end
        check("pause_no_ctrl", bad, 0);
        pause    = 1'b0;
        seen_rot = 0;
        n        = 0;
        do begin
            step();
            tot++;
            n++;
            if (ctrl == 3'd3) seen_rot++;
        end while (ctrl != 3'd4 && n < 300);
        check("pause_rotate_once", seen_rot, 1);
        check("pause_grav_resume", tot, 602);

        // reset during WAIT with DROP pending
        btn_req = 6'b000001;
        step();
        btn_req = '0;
        wait_cmd(1, 20, n);
        ready = 1'b0;
        step();
        step();
        btn_req = 6'b010000;
        step();
        btn_req = '0;
        check("pre_reset_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", int'(ctrl), 0);
        check("async_reset_busy", int'(busy), 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ready   = 1'b1;
        bad     = 0;
        repeat (20) begin
            step();
            if (ctrl == 3'd5) bad++;
        end
        check("no_drop_replay", bad, 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            btn_req = 6'($urandom & $urandom & $urandom);
            ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) pause = ~pause;
            if ($urandom_range(0, 199) == 0) level = 4'($urandom_range(0, 15));
            step();
        end
        btn_req = '0;
        pause   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
